// File: rtl/mem_dcache_if.sv
// mem_dcache_if: CPU request/response and mem_ctrl handshake bundle for mem_dcache.
interface mem_dcache_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_we_in;
    logic [2:0]  req_funct3_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic [31:0] resp_data_out;
    logic        mc_read_req_out;
    logic        mc_write_req_out;
    logic [31:0] mc_addr_out;
    logic [31:0] mc_wdata_out;
    logic [2:0]  mc_len_out;
    logic [1:0]  mc_busy_in;
    logic        mc_done_in;
    logic [31:0] mc_rdata_in;
    modport slave (
        input  req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in,
               mc_busy_in, mc_done_in, mc_rdata_in,
        output req_ready_out, resp_valid_out, resp_data_out,
               mc_read_req_out, mc_write_req_out, mc_addr_out, mc_wdata_out, mc_len_out
    );
    modport master (
        output req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in,
               mc_busy_in, mc_done_in, mc_rdata_in,
        input  req_ready_out, resp_valid_out, resp_data_out,
               mc_read_req_out, mc_write_req_out, mc_addr_out, mc_wdata_out, mc_len_out
    );
endinterface

// File: rtl/mem_dcache.sv
// mem_dcache: direct-mapped write-through data cache between the MEM stage and mem_ctrl.
module mem_dcache #(
    parameter int          INDEX_BITS     = 8,
    parameter logic [31:0] UNCACHED_BASE  = 32'h30000,
    parameter bit          WRITE_ALLOCATE = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic flush_in,
    output logic stall_req_out,
    mem_dcache_if.slave bus
);
    localparam int LINES = 2 ** INDEX_BITS;
    localparam int TW = 30 - INDEX_BITS;
    typedef enum logic [2:0] {IDLE, HIT_RESP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [LINES-1:0] valid;
    logic [TW-1:0] tags [LINES];
    logic [31:0] lines [LINES];
    logic [2:0] op_f3;
    logic [31:0] op_addr, op_wdata, rdata_q;
    logic flush_pend;
    logic [INDEX_BITS-1:0] req_idx, op_idx;
    logic [TW-1:0] req_tag, op_tag;
    logic req_cacheable, op_cacheable, req_hit, op_hit, accept, mc_go;
    logic rd_issue, wr_issue, done, fill, unused_busy;
    logic [3:0] be;
    logic [31:0] mask, merged, hit_data, load_data, fill_line;

    function automatic logic aligned(input logic [2:0] f3, input logic [1:0] a);
        return f3[1] ? a == 2'b00 : f3[0] ? !a[0] : 1'b1;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        return f3[1] ? w : f3[0] ? {{16{w[15] & !f3[2]}}, w[15:0]} : {{24{w[7] & !f3[2]}}, w[7:0]};
    endfunction

    assign unused_busy   = bus.mc_busy_in[0];
    assign req_idx       = bus.req_addr_in[INDEX_BITS+1:2];
    assign req_tag       = bus.req_addr_in[31:INDEX_BITS+2];
    assign op_idx        = op_addr[INDEX_BITS+1:2];
    assign op_tag        = op_addr[31:INDEX_BITS+2];
    assign req_cacheable = bus.req_addr_in < UNCACHED_BASE && aligned(bus.req_funct3_in, bus.req_addr_in[1:0]);
    assign op_cacheable  = op_addr < UNCACHED_BASE && aligned(op_f3, op_addr[1:0]);
    assign req_hit       = req_cacheable && valid[req_idx] && tags[req_idx] == req_tag;
    assign op_hit        = op_cacheable && valid[op_idx] && tags[op_idx] == op_tag;
    assign accept        = bus.req_valid_in && bus.req_ready_out && !flush_in;
    assign mc_go         = !bus.mc_busy_in[1] && rdy_in;

    // Store merge: only the written byte lanes of a hit line change.
    assign be        = (op_f3[1] ? 4'b1111 : op_f3[0] ? 4'b0011 : 4'b0001) << op_addr[1:0];
    assign mask      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign merged    = (lines[op_idx] & ~mask) | ((op_wdata << {op_addr[1:0], 3'b000}) & mask);
    assign hit_data  = extend(bus.req_funct3_in, lines[req_idx] >> {bus.req_addr_in[1:0], 3'b000});
    assign load_data = extend(op_f3, op_cacheable ? bus.mc_rdata_in >> {op_addr[1:0], 3'b000} : bus.mc_rdata_in);
    assign done      = bus.mc_done_in && (state == RD_WAIT || state == WR_WAIT);
    assign fill      = done && op_cacheable && (state == RD_WAIT || op_hit || (WRITE_ALLOCATE && op_f3 == 3'b010));
    assign fill_line = state == RD_WAIT ? bus.mc_rdata_in : op_hit ? merged : op_wdata;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bus.req_we_in ? WR_REQ : req_hit ? HIT_RESP : RD_REQ;
            RD_REQ:  if (mc_go) state_nx = RD_WAIT;
            WR_REQ:  if (mc_go) state_nx = WR_WAIT;
            RD_WAIT: if (bus.mc_done_in) state_nx = RESP;
            WR_WAIT: if (bus.mc_done_in) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Requests only rise while mem_ctrl can accept and are then held until done.
    assign rd_issue             = state == RD_WAIT || (state == RD_REQ && mc_go);
    assign wr_issue             = state == WR_WAIT || (state == WR_REQ && mc_go);
    assign bus.mc_read_req_out  = rd_issue;
    assign bus.mc_write_req_out = wr_issue;
    assign bus.mc_addr_out      = !(rd_issue || wr_issue) ? '0 : rd_issue && op_cacheable ? {op_addr[31:2], 2'b00} : op_addr;
    assign bus.mc_wdata_out     = wr_issue ? op_wdata : '0;
    assign bus.mc_len_out       = wr_issue ? (op_f3[1] ? 3'd3 : {2'b00, op_f3[0]}) : !rd_issue ? 3'd0 :
                                  (op_cacheable || op_f3[1]) ? 3'd4 : op_f3[0] ? 3'd2 : 3'd1;
    assign bus.req_ready_out    = state == IDLE && !flush_pend;
    assign bus.resp_valid_out   = state == HIT_RESP || state == RESP;
    assign bus.resp_data_out    = bus.resp_valid_out ? rdata_q : '0;
    assign stall_req_out        = state != IDLE;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            op_f3      <= '0;
            op_addr    <= '0;
            op_wdata   <= '0;
            rdata_q    <= '0;
        end else if (rdy_in) begin
            state      <= state_nx;
            flush_pend <= state == IDLE ? 1'b0 : flush_pend || flush_in;
            if (accept) begin
                op_f3    <= bus.req_funct3_in;
                op_addr  <= bus.req_addr_in;
                op_wdata <= bus.req_wdata_in;
                rdata_q  <= bus.req_we_in ? '0 : hit_data;
            end
            if (state == RD_WAIT && bus.mc_done_in) rdata_q <= load_data;
            if (state == IDLE && (flush_in || flush_pend)) valid <= '0;
            else if (fill) valid[op_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && fill) begin
            tags[op_idx]  <= op_tag;
            lines[op_idx] <= fill_line;
        end
    end
endmodule

// File: tb/tb_mem_dcache.sv
// tb_mem_dcache: directed checks of mem_dcache with a 3-cycle mem_ctrl responder.
module tb_mem_dcache;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
    logic stall_a, stall_b;
    int tests = 0, fails = 0;
    logic [31:0] r_data, r_addr, r_wdata;
    logic [2:0] r_len;
    int r_cyc, r_nrd, r_nwr;
    logic b_resp1, b_rd1;

    mem_dcache_if ia();
    mem_dcache_if ib();

    always #5 clk_in = ~clk_in;

    mem_dcache #(.WRITE_ALLOCATE(1'b1)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .stall_req_out(stall_a), .bus(ia)
    );
    mem_dcache #(.WRITE_ALLOCATE(1'b0)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .stall_req_out(stall_b), .bus(ib)
    );

    assign ib.req_valid_in  = ia.req_valid_in;
    assign ib.req_we_in     = ia.req_we_in;
    assign ib.req_funct3_in = ia.req_funct3_in;
    assign ib.req_addr_in   = ia.req_addr_in;
    assign ib.req_wdata_in  = ia.req_wdata_in;
    assign ib.mc_busy_in    = ia.mc_busy_in;
    assign ib.mc_done_in    = ia.mc_done_in;
    assign ib.mc_rdata_in   = ia.mc_rdata_in;

    task automatic wait_ready();
        for (int i = 0; i < 20 && !ia.req_ready_out; i++) @(negedge clk_in);
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
        int w = 0;
        logic prev = 1'b0;
        r_nrd = 0; r_nwr = 0; r_addr = '0; r_len = '0; r_wdata = '0;
        wait_ready();
        ia.req_valid_in = 1'b1; ia.req_we_in = we; ia.req_funct3_in = f3; ia.req_addr_in = addr; ia.req_wdata_in = wd;
        @(negedge clk_in);
        ia.req_valid_in = 1'b0;
        r_cyc = 1;
        b_resp1 = ib.resp_valid_out;
        b_rd1 = ib.mc_read_req_out;
        while (!ia.resp_valid_out && r_cyc < 40) begin
            if (ia.mc_read_req_out || ia.mc_write_req_out) begin
                if (!prev && ia.mc_read_req_out) r_nrd++;
                if (!prev && ia.mc_write_req_out) r_nwr++;
                r_addr = ia.mc_addr_out; r_len = ia.mc_len_out; r_wdata = ia.mc_wdata_out;
                w++;
                if (w == 3) begin ia.mc_done_in = 1'b1; ia.mc_rdata_in = rd; end
            end
            prev = ia.mc_read_req_out || ia.mc_write_req_out;
            @(negedge clk_in);
            ia.mc_done_in = 1'b0;
            r_cyc++;
        end
        tests++;
        if (ia.resp_valid_out !== 1'b1) begin fails++; $display("FAIL op_timeout addr=%h got no resp, expected resp", addr); end
        r_data = ia.resp_data_out;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        tests++; if (ia.req_ready_out !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", ia.req_ready_out); end
        tests++; if ({ia.resp_valid_out, stall_a, ia.mc_read_req_out, ia.mc_write_req_out} !== 4'b0) begin
            fails++; $display("FAIL rst_ctrl got=%b exp=0000", {ia.resp_valid_out, stall_a, ia.mc_read_req_out, ia.mc_write_req_out}); end
        tests++; if ({ia.mc_addr_out, ia.mc_wdata_out, ia.resp_data_out, ia.mc_len_out} !== '0) begin
            fails++; $display("FAIL rst_data got=%h exp=0", {ia.mc_addr_out, ia.mc_wdata_out, ia.resp_data_out, ia.mc_len_out}); end
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_load_miss_hit();
        op(1'b0, LW, 32'h100, 32'h0, 32'hDEADBEEF);
        tests++; if (r_data !== 32'hDEADBEEF) begin fails++; $display("FAIL miss_data got=%h exp=deadbeef", r_data); end
        tests++; if (r_nrd !== 1 || r_len !== 3'd4 || r_addr !== 32'h100) begin
            fails++; $display("FAIL miss_req got nrd=%0d len=%0d addr=%h exp 1/4/100", r_nrd, r_len, r_addr); end
        tests++; if (r_cyc !== 4) begin fails++; $display("FAIL miss_latency got=%0d exp=4", r_cyc); end
        op(1'b0, LW, 32'h100, 32'h0, 32'h0);
        tests++; if (r_data !== 32'hDEADBEEF) begin fails++; $display("FAIL hit_data got=%h exp=deadbeef", r_data); end
        tests++; if (r_cyc !== 1 || r_nrd !== 0) begin fails++; $display("FAIL hit_latency got cyc=%0d nrd=%0d exp 1/0", r_cyc, r_nrd); end
    endtask

    task automatic test_extend();
        op(1'b1, LW, 32'h100, 32'h8081FF7F, 32'h0);
        tests++; if (r_nwr !== 1 || r_len !== 3'd3 || r_addr !== 32'h100 || r_wdata !== 32'h8081FF7F || r_data !== 32'h0) begin
            fails++; $display("FAIL sw_req got nwr=%0d len=%0d addr=%h wd=%h resp=%h", r_nwr, r_len, r_addr, r_wdata, r_data); end
        op(1'b0, LB, 32'h100, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h0000007F || r_cyc !== 1) begin fails++; $display("FAIL lb_100 got=%h cyc=%0d exp=0000007f/1", r_data, r_cyc); end
        op(1'b0, LB, 32'h101, 32'h0, 32'h0);
        tests++; if (r_data !== 32'hFFFFFFFF) begin fails++; $display("FAIL lb_101 got=%h exp=ffffffff", r_data); end
        op(1'b0, LBU, 32'h102, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h00000081) begin fails++; $display("FAIL lbu_102 got=%h exp=00000081", r_data); end
        op(1'b0, LH, 32'h102, 32'h0, 32'h0);
        tests++; if (r_data !== 32'hFFFF8081) begin fails++; $display("FAIL lh_102 got=%h exp=ffff8081", r_data); end
        op(1'b0, LHU, 32'h102, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h00008081 || r_nrd !== 0) begin fails++; $display("FAIL lhu_102 got=%h nrd=%0d exp=00008081/0", r_data, r_nrd); end
    endtask

    task automatic test_store_merge();
        op(1'b0, LW, 32'h200, 32'h0, 32'h11223344);
        op(1'b1, LB, 32'h201, 32'hFFFFFFAA, 32'h0);
        tests++; if (r_len !== 3'd0 || r_addr !== 32'h201 || r_wdata !== 32'hFFFFFFAA) begin
            fails++; $display("FAIL sb_req got len=%0d addr=%h wd=%h exp 0/201/ffffffaa", r_len, r_addr, r_wdata); end
        op(1'b0, LW, 32'h200, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h1122AA44 || r_cyc !== 1) begin fails++; $display("FAIL sb_merge got=%h cyc=%0d exp=1122aa44/1", r_data, r_cyc); end
        op(1'b1, LH, 32'h202, 32'h0000BEEF, 32'h0);
        tests++; if (r_len !== 3'd1 || r_addr !== 32'h202) begin fails++; $display("FAIL sh_req got len=%0d addr=%h exp 1/202", r_len, r_addr); end
        op(1'b0, LW, 32'h200, 32'h0, 32'h0);
        tests++; if (r_data !== 32'hBEEFAA44) begin fails++; $display("FAIL sh_merge got=%h exp=beefaa44", r_data); end
    endtask

    task automatic test_uncached();
        op(1'b0, LB, 32'h30000, 32'h0, 32'h123456F0);
        tests++; if (r_data !== 32'hFFFFFFF0 || r_nrd !== 1 || r_len !== 3'd1 || r_addr !== 32'h30000) begin
            fails++; $display("FAIL io_lb1 got=%h nrd=%0d len=%0d addr=%h", r_data, r_nrd, r_len, r_addr); end
        op(1'b0, LB, 32'h30000, 32'h0, 32'h00000011);
        tests++; if (r_data !== 32'h00000011 || r_nrd !== 1 || r_cyc !== 4) begin
            fails++; $display("FAIL io_lb2 got=%h nrd=%0d cyc=%0d exp 11/1/4", r_data, r_nrd, r_cyc); end
        op(1'b0, LHU, 32'h30002, 32'h0, 32'h00009ABC);
        tests++; if (r_data !== 32'h00009ABC || r_len !== 3'd2 || r_addr !== 32'h30002) begin
            fails++; $display("FAIL io_lhu got=%h len=%0d addr=%h exp 9abc/2/30002", r_data, r_len, r_addr); end
        op(1'b0, LW, 32'h102, 32'h0, 32'hCAFEBABE);
        tests++; if (r_data !== 32'hCAFEBABE || r_addr !== 32'h102 || r_len !== 3'd4 || r_nrd !== 1) begin
            fails++; $display("FAIL misaligned got=%h addr=%h len=%0d nrd=%0d", r_data, r_addr, r_len, r_nrd); end
        op(1'b0, LW, 32'h100, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h8081FF7F || r_cyc !== 1) begin fails++; $display("FAIL nofill got=%h cyc=%0d exp=8081ff7f/1", r_data, r_cyc); end
    endtask

    task automatic test_write_allocate();
        op(1'b1, LW, 32'h300, 32'h55AA55AA, 32'h0);
        tests++; if (r_nwr !== 1) begin fails++; $display("FAIL sw_miss_wr got=%0d exp=1", r_nwr); end
        op(1'b0, LW, 32'h300, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h55AA55AA || r_cyc !== 1) begin fails++; $display("FAIL wa1_hit got=%h cyc=%0d exp=55aa55aa/1", r_data, r_cyc); end
        tests++; if (b_resp1 !== 1'b0 || b_rd1 !== 1'b1) begin fails++; $display("FAIL wa0_miss got resp=%b rd=%b exp 0/1", b_resp1, b_rd1); end
        op(1'b0, LW, 32'h700, 32'h0, 32'h77777777);
        tests++; if (r_data !== 32'h77777777 || r_nrd !== 1) begin fails++; $display("FAIL alias_miss got=%h nrd=%0d", r_data, r_nrd); end
        op(1'b0, LW, 32'h300, 32'h0, 32'h33333333);
        tests++; if (r_data !== 32'h33333333 || r_nrd !== 1) begin fails++; $display("FAIL evicted got=%h nrd=%0d exp 33333333/1", r_data, r_nrd); end
    endtask

    task automatic test_busy_flush();
        ia.mc_busy_in = 2'b10;
        wait_ready();
        ia.req_valid_in = 1'b1; ia.req_we_in = 1'b0; ia.req_funct3_in = LW; ia.req_addr_in = 32'h500;
        @(negedge clk_in);
        ia.req_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (ia.mc_read_req_out !== 1'b0 || stall_a !== 1'b1) begin
                fails++; $display("FAIL busy_hold got rd=%b stall=%b exp 0/1", ia.mc_read_req_out, stall_a); end
            @(negedge clk_in);
        end
        ia.mc_busy_in = 2'b00;
        #1;
        tests++; if (ia.mc_read_req_out !== 1'b1 || ia.mc_addr_out !== 32'h500) begin
            fails++; $display("FAIL busy_release got rd=%b addr=%h exp 1/500", ia.mc_read_req_out, ia.mc_addr_out); end
        @(negedge clk_in);
        flush_in = 1'b1; ia.mc_done_in = 1'b1; ia.mc_rdata_in = 32'h5A5A5A5A;
        @(negedge clk_in);
        flush_in = 1'b0; ia.mc_done_in = 1'b0;
        tests++; if (ia.resp_valid_out !== 1'b1 || ia.resp_data_out !== 32'h5A5A5A5A) begin
            fails++; $display("FAIL flush_fill_resp got v=%b d=%h exp 1/5a5a5a5a", ia.resp_valid_out, ia.resp_data_out); end
        @(negedge clk_in);
        tests++; if (ia.req_ready_out !== 1'b0) begin fails++; $display("FAIL flush_pend_ready got=%b exp=0", ia.req_ready_out); end
        @(negedge clk_in);
        tests++; if (ia.req_ready_out !== 1'b1) begin fails++; $display("FAIL flush_done_ready got=%b exp=1", ia.req_ready_out); end
        op(1'b0, LW, 32'h500, 32'h0, 32'h66666666);
        tests++; if (r_nrd !== 1 || r_data !== 32'h66666666) begin fails++; $display("FAIL flushed_miss got nrd=%0d d=%h", r_nrd, r_data); end
        wait_ready();
        flush_in = 1'b1; ia.req_valid_in = 1'b1; ia.req_addr_in = 32'h500;
        @(negedge clk_in);
        flush_in = 1'b0; ia.req_valid_in = 1'b0;
        tests++; if (stall_a !== 1'b0) begin fails++; $display("FAIL flush_blocks_req got stall=%b exp=0", stall_a); end
        op(1'b0, LW, 32'h500, 32'h0, 32'h77770000);
        tests++; if (r_nrd !== 1) begin fails++; $display("FAIL idle_flush_miss got nrd=%0d exp=1", r_nrd); end
    endtask

    task automatic test_rdy_freeze();
        wait_ready();
        rdy_in = 1'b0;
        ia.req_valid_in = 1'b1; ia.req_funct3_in = LB; ia.req_addr_in = 32'h30000;
        repeat (3) @(negedge clk_in);
        tests++; if (stall_a !== 1'b0 || ia.mc_read_req_out !== 1'b0) begin
            fails++; $display("FAIL rdy_freeze got stall=%b rd=%b exp 0/0", stall_a, ia.mc_read_req_out); end
        ia.req_valid_in = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_reset_midop();
        wait_ready();
        ia.req_valid_in = 1'b1; ia.req_we_in = 1'b1; ia.req_funct3_in = LW; ia.req_addr_in = 32'h104; ia.req_wdata_in = 32'h12345678;
        @(negedge clk_in);
        ia.req_valid_in = 1'b0;
        @(negedge clk_in);
        tests++; if (ia.mc_write_req_out !== 1'b1) begin fails++; $display("FAIL wr_wait_req got=%b exp=1", ia.mc_write_req_out); end
        rst_in = 1'b0;
        #1;
        tests++; if ({ia.mc_write_req_out, stall_a, ia.resp_valid_out} !== 3'b000 || ia.mc_addr_out !== 32'h0 || ia.req_ready_out !== 1'b1) begin
            fails++; $display("FAIL rst_midop got ctrl=%b addr=%h rdy=%b exp 000/0/1",
                              {ia.mc_write_req_out, stall_a, ia.resp_valid_out}, ia.mc_addr_out, ia.req_ready_out); end
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        op(1'b0, LW, 32'h500, 32'h0, 32'h0BADF00D);
        tests++; if (r_nrd !== 1 || r_data !== 32'h0BADF00D) begin fails++; $display("FAIL rst_invalidate got nrd=%0d d=%h", r_nrd, r_data); end
    endtask

    initial begin
        ia.req_valid_in = 1'b0; ia.req_we_in = 1'b0; ia.req_funct3_in = '0; ia.req_addr_in = '0; ia.req_wdata_in = '0;
        ia.mc_busy_in = 2'b00; ia.mc_done_in = 1'b0; ia.mc_rdata_in = '0;
        test_reset();
        test_load_miss_hit();
        test_extend();
        test_store_merge();
        test_uncached();
        test_write_allocate();
        test_busy_flush();
        test_rdy_freeze();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
